// File: rtl/alu_result_bcd_if.sv
// Handshake and result bundle between the calculator datapath and the
// binary-to-BCD converter.
interface alu_result_bcd_if #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
);
    logic                  start;
    logic [WIDTH-1:0]      value;
    logic                  is_signed;
    logic                  busy;
    logic                  done;
    logic                  neg;
    logic [4*DIGITS-1:0]   bcd;
    logic [3:0]            ndigits;

    modport master (
        output start, value, is_signed,
        input  busy, done, neg, bcd, ndigits
    );

    modport slave (
        input  start, value, is_signed,
        output busy, done, neg, bcd, ndigits
    );
endinterface

// File: rtl/alu_result_bcd.sv
// Sequential double-dabble converter: turns the ALU result into sign,
// packed BCD digits and a significant-digit count, one bit per clock.
module alu_result_bcd #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10,
    parameter int CNTW   = 6
) (
    input logic          clk,
    input logic          reset,
    alu_result_bcd_if.slave bus
);
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t               state, state_next;
    logic [CNTW-1:0]      cnt;
    logic [WIDTH-1:0]     bin_work;
    logic [4*DIGITS-1:0]  bcd_work;
    logic                 neg_work;

    logic                 busy_q, done_q, neg_q;
    logic [4*DIGITS-1:0]  bcd_q;
    logic [3:0]           ndigits_q;

    logic                 in_neg;
    logic [WIDTH-1:0]     in_mag;
    logic [4*DIGITS-1:0]  adj;
    logic [4*DIGITS-1:0]  shift_bcd;
    logic [3:0]           ndig;
    logic                 last;

    // Magnitude of the operand; the most-negative value maps onto itself.
    always_comb begin
        in_neg = bus.is_signed & bus.value[WIDTH-1];
        in_mag = in_neg ? (~bus.value + WIDTH'(1)) : bus.value;
    end

    always_comb begin
        adj = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            adj[4*i +: 4] = (bcd_work[4*i +: 4] >= 4'd5) ? bcd_work[4*i +: 4] + 4'd3
                                                        : bcd_work[4*i +: 4];
        end
        shift_bcd = {adj[4*DIGITS-2:0], bin_work[WIDTH-1]};
    end

    always_comb begin
        ndig = 4'd1;
        for (int unsigned i = 1; i < DIGITS; i++) begin
            if (shift_bcd[4*i +: 4] != 4'd0)
                ndig = 4'(i + 1);
        end
    end

    assign last = (cnt == CNTW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = SHIFT;
            SHIFT:   if (last)      state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            bin_work  <= '0;
            bcd_work  <= '0;
            neg_work  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            neg_q     <= 1'b0;
            bcd_q     <= '0;
            ndigits_q <= 4'd1;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bin_work <= in_mag;
                        bcd_work <= '0;
                        neg_work <= in_neg;
                        cnt      <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                SHIFT: begin
                    bcd_work <= shift_bcd;
                    bin_work <= {bin_work[WIDTH-2:0], 1'b0};
                    cnt      <= cnt + CNTW'(1);
                    // Final shift: publish the result straight from the shifter.
                    if (last) begin
                        bcd_q     <= shift_bcd;
                        neg_q     <= neg_work;
                        ndigits_q <= ndig;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.neg     = neg_q;
    assign bus.bcd     = bcd_q;
    assign bus.ndigits = ndigits_q;
endmodule

// File: doc/alu_result_bcd.md
Name: alu_result_bcd

Overview:
- Sequential binary-to-BCD converter directly downstream of alu32.
- Takes the 32-bit aluout word and produces packed BCD digits, a sign flag and a significant-digit count for the calculator's display driver.
- Uses iterative shift-add-3 (double dabble), one result bit per clock, with a start/busy/done handshake so the display path never depends on a long combinational chain.

Parameters:
- WIDTH, 32, bit width of the binary input (matches the aluout width).
- DIGITS, 10, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH-1.
- CNTW, 6, width of the internal shift counter; must hold the value WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a conversion; sampled only in IDLE.
- value  input  WIDTH  binary operand, normally aluout.
- is_signed  input  1  1: treat value as two's complement; 0: unsigned.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse when a new result is committed.
- neg  output  1  sign of the last committed result.
- bcd  output  4*DIGITS  packed BCD, digit 0 (units) in bits [3:0].
- ndigits  output  4  count of significant digits in the last result, 1..DIGITS.

Behaviour:
- Reset: synchronous, active-high.
  - Outputs: busy=0, done=0, neg=0, bcd=0, ndigits=1.
  - Internals: state=IDLE, shift counter cleared, working registers cleared.
- States: IDLE, SHIFT.
- IDLE:
  - On an edge with start=1:
    - Compute the magnitude: if is_signed=1 and value[WIDTH-1]=1, mag = (~value)+1 truncated to WIDTH bits and neg_next=1; otherwise mag = value and neg_next=0.
    - Load mag into the binary shift register and clear the BCD working register.
    - Set counter=0, busy=1, state=SHIFT.
  - With start=0: hold.
- SHIFT, each edge:
  - Every 4-bit working digit >= 5 gets +3.
  - Then shift {bcd_work, bin} left by one and increment the counter.
- Commit edge (the edge performing the WIDTH-th shift):
  - Copy the final working digits to bcd, neg_next to neg, and the computed significant-digit count to ndigits.
  - Set done=1, busy=0, state=IDLE.
- Latency: if start is sampled at edge N, done is high in the cycle after edge N+WIDTH (32 cycles for default parameters).
- done:
  - High for exactly one cycle.
  - Cleared on the next edge unless another commit occurs on that edge. Back-to-back commits cannot occur: the minimum spacing is WIDTH+1 edges.
- bcd, neg, ndigits:
  - Change only on a commit edge or reset.
  - Hold their values through subsequent conversions until the next commit.
- ndigits:
  - Equals 1 + the index of the highest non-zero digit.
  - A zero result gives ndigits=1 and bcd=0.
- Input capture: value and is_signed are captured only at the accepting edge; changes afterwards have no effect on the running conversion.
- start while busy=1: ignored, with no queueing.
- start=1 in the cycle where done=1: accepted, because state is already IDLE.
- Most-negative input (is_signed=1, value=0x80000000): magnitude 0x80000000 is converted as unsigned 2147483648 with neg=1. No overflow flag is required.
- Reset during SHIFT:
  - Aborts the conversion; no done pulse is produced.
  - bcd, neg and ndigits return to their reset values on that edge.
- Reset has priority over start on the same edge.

Test Plan:
- Unsigned 12: reset, then start=1 for one cycle with value=0x0000000C, is_signed=0.
  - Required: busy=1 for 32 cycles; done pulses at N+32; bcd=0x0000000012, neg=0, ndigits=2.
- Unsigned maximum: value=0xFFFFFFFF, is_signed=0.
  - Required: bcd=0x4294967295, neg=0, ndigits=10.
- Signed -1 and signed minimum:
  - value=0xFFFFFFFF, is_signed=1: bcd=0x0000000001, neg=1, ndigits=1.
  - value=0x80000000, is_signed=1: bcd=0x2147483648, neg=1, ndigits=10.
- Zero and result hold: value=0, any is_signed.
  - Required: bcd=0, neg=0, ndigits=1.
  - Start a second conversion: the previous bcd stays stable until the new done.
- Handshake corners:
  - Pulse start again at cycle 10 of a conversion while changing value: ignored; the result matches the first operand, with one done pulse only.
  - Hold start=1 through done: a new conversion begins on the done cycle, and the next done follows 32 edges later.
- Reset mid-conversion: assert reset at cycle 15 of a conversion of 0x0000000C.
  - Required: busy=0 and done never pulses; bcd=0, ndigits=1.
  - After reset deasserts, a fresh start converts correctly.
